// File: rtl/uart_transmitter_pkg.sv
// Shared UART constants: default baud divider, TX/RX state encodings,
// bus register offsets and STATUS bit positions. The RX peripheral
// imports the same package so both sides agree on the register map.
package uart_transmitter_pkg;

  // 27 MHz system clock / 115200 baud
  localparam int unsigned DEF_DELAY_FRAMES = 234;

  // Register offsets (low address bits)
  localparam logic [3:0] OFF_TXWORD = 4'h0;
  localparam logic [3:0] OFF_TXBYTE = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;

  // STATUS word bit positions
  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_OVERRUN_BIT = 1;

  // Transmitter states
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Receiver states, kept here so both directions share one encoding table
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Pack the STATUS register: {30'b0, overrun, busy}
  function automatic logic [31:0] status_word(input logic overrun, input logic busy);
    logic [31:0] w;
    w = '0;
    w[STATUS_OVERRUN_BIT] = overrun;
    w[STATUS_BUSY_BIT]    = busy;
    return w;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate divider: counts 0..DELAY_FRAMES-1 and pulses o_tick on the
// last count of every bit period. i_clear holds the counter at zero so a
// frame always starts on a full-length bit. Reusable by the RX block.
module uart_baud_tick #(
  parameter int unsigned DELAY_FRAMES = 234
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int unsigned CNT_W = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DELAY_FRAMES - 1);

  logic [CNT_W-1:0] r_count;

  assign o_tick = (r_count == LAST_COUNT) && !i_clear;

  // Free-running bit-period counter, restarting at each bit boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear || o_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// Memory-mapped 8N1 UART transmitter. A write to TXWORD sends four bytes
// ([31:24] first), a write to TXBYTE sends data_in[7:0]. STATUS reports
// busy and a sticky overrun flag that clears when STATUS is read.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int unsigned DELAY_FRAMES = DEF_DELAY_FRAMES,
  parameter int unsigned ADDR_BITS    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        uart_tx
);

  tx_state_t r_state;
  tx_state_t w_state_next;

  logic [31:0] r_shift;
  logic [31:0] w_shift_next;
  logic [2:0]  r_bytes_left;
  logic [2:0]  w_bytes_left_next;
  logic [2:0]  r_bit_idx;
  logic [2:0]  w_bit_idx_next;
  logic        r_tx;
  logic        w_tx_next;
  logic        r_overrun;
  logic [31:0] r_data_out;

  logic                 w_tick;
  logic                 w_baud_clear;
  logic [ADDR_BITS-1:0] w_offset;
  logic                 w_sel_word;
  logic                 w_sel_byte;
  logic                 w_sel_status;
  logic                 w_wr_tx;
  logic                 w_busy;
  logic                 w_accept;
  logic                 w_overrun_set;
  logic                 w_status_rd;
  logic [7:0]           w_cur_byte;
  logic [2:0]           w_bit_idx_inc;
  logic                 w_unused_addr;

  // Only the low address bits select a register
  assign w_offset      = address[ADDR_BITS-1:0];
  assign w_unused_addr = ^address[31:ADDR_BITS];
  assign w_sel_word    = (w_offset == ADDR_BITS'(OFF_TXWORD));
  assign w_sel_byte    = (w_offset == ADDR_BITS'(OFF_TXBYTE));
  assign w_sel_status  = (w_offset == ADDR_BITS'(OFF_STATUS));

  assign w_busy        = (r_state != TX_IDLE);
  assign w_wr_tx       = write_enable && (w_sel_word || w_sel_byte);
  assign w_accept      = w_wr_tx && !w_busy;
  assign w_overrun_set = w_wr_tx && w_busy;
  assign w_status_rd   = read_enable && w_sel_status;

  // The byte on the wire is always the top byte of the shift word
  assign w_cur_byte    = r_shift[31:24];
  assign w_bit_idx_inc = r_bit_idx + 3'd1;

  // Counter only runs while a frame is in flight
  assign w_baud_clear  = (r_state == TX_IDLE);

  uart_baud_tick #(
    .DELAY_FRAMES(DELAY_FRAMES)
  ) u_baud_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clear(w_baud_clear),
    .o_tick (w_tick)
  );

  // Next-state logic; also decides the next line level so the line and
  // the state update on the same edge
  always_comb begin
    w_state_next      = r_state;
    w_shift_next      = r_shift;
    w_bytes_left_next = r_bytes_left;
    w_bit_idx_next    = r_bit_idx;
    w_tx_next         = r_tx;
    case (r_state)
      TX_IDLE: begin
        w_tx_next = 1'b1;
        if (w_accept) begin
          w_state_next      = TX_START;
          w_tx_next         = 1'b0;
          w_bit_idx_next    = 3'd0;
          w_shift_next      = w_sel_word ? data_in : {data_in[7:0], 24'h0};
          w_bytes_left_next = w_sel_word ? 3'd4 : 3'd1;
        end
      end
      TX_START: begin
        if (w_tick) begin
          w_state_next   = TX_DATA;
          w_bit_idx_next = 3'd0;
          w_tx_next      = w_cur_byte[0];
        end
      end
      TX_DATA: begin
        if (w_tick) begin
          if (r_bit_idx == 3'd7) begin
            w_state_next = TX_STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_bit_idx_next = w_bit_idx_inc;
            w_tx_next      = w_cur_byte[w_bit_idx_inc];
          end
        end
      end
      TX_STOP: begin
        if (w_tick) begin
          if (r_bytes_left > 3'd1) begin
            // Next byte follows immediately, no idle gap
            w_state_next      = TX_START;
            w_shift_next      = {r_shift[23:0], 8'h00};
            w_bytes_left_next = r_bytes_left - 3'd1;
            w_tx_next         = 1'b0;
          end else begin
            w_state_next      = TX_IDLE;
            w_bytes_left_next = 3'd0;
            w_tx_next         = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = TX_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  // FSM state, shift word, counters and serial line flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= TX_IDLE;
      r_shift      <= '0;
      r_bytes_left <= '0;
      r_bit_idx    <= '0;
      r_tx         <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_shift      <= w_shift_next;
      r_bytes_left <= w_bytes_left_next;
      r_bit_idx    <= w_bit_idx_next;
      r_tx         <= w_tx_next;
    end
  end

  // Sticky overrun: a new overrun in the same cycle as a STATUS read wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_overrun_set) begin
      r_overrun <= 1'b1;
    end else if (w_status_rd) begin
      r_overrun <= 1'b0;
    end
  end

  // Registered read data; zero whenever no STATUS read is in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
    end else if (w_status_rd) begin
      r_data_out <= status_word(r_overrun, w_busy);
    end else begin
      r_data_out <= '0;
    end
  end

  assign data_out = r_data_out;
  assign uart_tx  = r_tx;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: a serial-line monitor decodes
// frames independently while one initial block drives bus accesses and
// checks status words, decoded bytes and frame timing.
module tb_uart_transmitter;

  localparam int DF    = 234;
  localparam int FRAME = 10 * DF;

  logic        clk;
  logic        rst_n;
  logic        write_enable;
  logic        read_enable;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        uart_tx;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  uart_transmitter #(
    .DELAY_FRAMES(DF),
    .ADDR_BITS   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .write_enable(write_enable),
    .read_enable (read_enable),
    .address     (address),
    .data_in     (data_in),
    .data_out    (data_out),
    .uart_tx     (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Serial line monitor: samples mid-bit on the falling clock edge
  logic [7:0] mon_bytes[$];
  int         mon_starts[$];
  int         mon_bad = 0;
  bit         mon_active = 1'b0;
  int         mon_off = 0;
  int         mon_start_cyc = 0;
  logic [7:0] mon_shift = 8'h00;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_active <= 1'b0;
    end else if (!mon_active) begin
      if (uart_tx === 1'b0) begin
        mon_active    <= 1'b1;
        mon_off       <= 1;
        mon_start_cyc <= cyc;
      end
    end else begin
      mon_off <= mon_off + 1;
      if ((mon_off % DF) == DF / 2) begin
        if ((mon_off / DF) == 0) begin
          if (uart_tx !== 1'b0) mon_bad <= mon_bad + 1;
        end else if ((mon_off / DF) <= 8) begin
          mon_shift <= {uart_tx, mon_shift[7:1]};
        end else begin
          if (uart_tx !== 1'b1) mon_bad <= mon_bad + 1;
          mon_bytes.push_back(mon_shift);
          mon_starts.push_back(mon_start_cyc);
          mon_active <= 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed time=%0t required<2ms", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Write strobe for one cycle; e returns the posedge number that samples it
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int e);
    @(negedge clk);
    address      = a;
    data_in      = d;
    write_enable = 1'b1;
    e            = cyc + 1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  // Read strobe sampled at posedge e; returns data_out after that edge
  task automatic read_at(input logic [31:0] a, input int e, output logic [31:0] v);
    wait_to(e - 1);
    address     = a;
    read_enable = 1'b1;
    @(negedge clk);
    read_enable = 1'b0;
    v           = data_out;
  endtask

  task automatic read_now(input logic [31:0] a, output logic [31:0] v);
    read_at(a, cyc + 2, v);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] word;
    int p;
    int q;

    rst_n        = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    address      = '0;
    data_in      = '0;

    // 1: reset values
    #23;
    chk("reset_tx", {31'h0, uart_tx}, 32'h1);
    chk("reset_dout", data_out, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    read_now(32'h8, v);
    chk("reset_status", v, 32'h0);
    @(negedge clk);
    chk("dout_no_read", data_out, 32'h0);
    $display("step reset: status=0x%08h", v);

    // 2: single byte 0x41
    mon_bytes.delete();
    mon_starts.delete();
    bus_write(32'h4, 32'h0000_0041, p);
    read_at(32'h8, p + 1, v);
    chk("byte_busy_start", v, 32'h1);
    read_at(32'hC, p + 5, v);
    chk("read_other_off", v, 32'h0);
    read_at(32'h8, p + FRAME, v);
    chk("byte_busy_last", v, 32'h1);
    read_at(32'h8, p + FRAME + 1, v);
    chk("byte_idle_after", v, 32'h0);
    wait_to(p + FRAME + 3);
    chk("byte_count", mon_bytes.size(), 1);
    if (mon_bytes.size() > 0) begin
      chk("byte_value", {24'h0, mon_bytes[0]}, 32'h41);
      chk("byte_start_cyc", mon_starts[0], p);
    end
    chk("byte_framing", mon_bad, 0);
    $display("step txbyte 0x41: frames=%0d", mon_bytes.size());

    // 3: word 0xDEADBEEF, four back-to-back frames
    mon_bytes.delete();
    mon_starts.delete();
    bus_write(32'h0, 32'hDEAD_BEEF, p);
    read_at(32'h8, p + 4 * FRAME, v);
    chk("word_busy_last", v, 32'h1);
    read_at(32'h8, p + 4 * FRAME + 1, v);
    chk("word_idle_after", v, 32'h0);
    wait_to(p + 4 * FRAME + 3);
    chk("word_count", mon_bytes.size(), 4);
    if (mon_bytes.size() == 4) begin
      word = {mon_bytes[0], mon_bytes[1], mon_bytes[2], mon_bytes[3]};
      chk("word_value", word, 32'hDEAD_BEEF);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("word_start%0d", i), mon_starts[i], p + i * FRAME);
      end
    end
    chk("word_framing", mon_bad, 0);
    $display("step txword 0xDEADBEEF: frames=%0d", mon_bytes.size());

    // 4: overrun while busy
    mon_bytes.delete();
    mon_starts.delete();
    bus_write(32'h4, 32'h0000_00A5, p);
    wait_to(p + 600);
    bus_write(32'h4, 32'h0000_005A, q);
    read_at(32'h8, p + 700, v);
    chk("ovr_status", v, 32'h3);
    read_at(32'h8, p + 701, v);
    chk("ovr_cleared", v, 32'h1);
    wait_to(p + FRAME + 5);
    chk("ovr_count", mon_bytes.size(), 1);
    if (mon_bytes.size() > 0) chk("ovr_value", {24'h0, mon_bytes[0]}, 32'hA5);
    read_now(32'h8, v);
    chk("ovr_status_end", v, 32'h0);
    $display("step overrun: frames=%0d", mon_bytes.size());

    // Write to an undecoded offset is ignored
    mon_bytes.delete();
    bus_write(32'hC, 32'h0000_00FF, p);
    wait_to(p + 400);
    read_now(32'h8, v);
    chk("bad_off_status", v, 32'h0);
    chk("bad_off_frames", mon_bytes.size(), 0);
    $display("step write 0xC: status=0x%08h", v);

    // 5: asynchronous reset during DATA bit 3 of a 0x00 frame
    mon_bytes.delete();
    mon_starts.delete();
    bus_write(32'h4, 32'h0000_0000, p);
    wait_to(p + 998);
    address     = 32'h8;
    read_enable = 1'b1;
    wait_to(p + 1000);
    #2;
    chk("pre_rst_tx", {31'h0, uart_tx}, 32'h0);
    chk("pre_rst_dout", data_out, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", {31'h0, uart_tx}, 32'h1);
    chk("async_rst_dout", data_out, 32'h0);
    read_enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    read_now(32'h8, v);
    chk("post_rst_status", v, 32'h0);
    chk("post_rst_frames", mon_bytes.size(), 0);
    bus_write(32'h4, 32'h0000_0055, p);
    wait_to(p + FRAME + 3);
    chk("post_rst_count", mon_bytes.size(), 1);
    if (mon_bytes.size() > 0) chk("post_rst_value", {24'h0, mon_bytes[0]}, 32'h55);
    chk("post_rst_framing", mon_bad, 0);
    $display("step reset mid-frame then 0x55: frames=%0d", mon_bytes.size());

    // 6: loopback of 0x12345678 through the monitor
    mon_bytes.delete();
    mon_starts.delete();
    bus_write(32'h0, 32'h1234_5678, p);
    wait_to(p + 4 * FRAME + 3);
    chk("loop_count", mon_bytes.size(), 4);
    if (mon_bytes.size() == 4) begin
      word = {mon_bytes[0], mon_bytes[1], mon_bytes[2], mon_bytes[3]};
      chk("loop_value", word, 32'h1234_5678);
    end
    chk("loop_framing", mon_bad, 0);
    $display("step loopback 0x12345678: frames=%0d", mon_bytes.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
